ahb_decode_mux: RTL and testbench
=================================

# ahb_decode_mux

Subordinate-side AHB interconnect stage: takes the single address/control bus driven by the multi-manager and fans it out to `SLAVE_COUNT` subordinates. It decodes the address into one-hot `HSEL` and registers the data-phase target. It multiplexes `HREADYOUT`/`HRESP`/`HRDATA` back to the manager side. A built-in default subordinate returns a two-cycle ERROR for active transfers to unmapped addresses.

## Interface
- `ADDR_WIDTH`, 32, address bus width
- `DATA_WIDTH`, 32, data bus width
- `SLAVE_COUNT`, 3, number of attached subordinates (1..8)
- `REGISTER_SELECT_BITS`, 12, low address bits passed through as the in-slave offset
- `SLAVE_SELECT_BITS`, 20, upper address bits compared against the slave index; `REGISTER_SELECT_BITS + SLAVE_SELECT_BITS == ADDR_WIDTH`

Ports:
- `i_hclk`  in  1  bus clock; all timing on the rising edge
- `i_hreset`  in  1  reset, asynchronous, active-low
- `i_haddr`  in  ADDR_WIDTH  address-phase address from the manager bus
- `i_htrans`  in  2  transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- `i_hreadyout`  in  SLAVE_COUNT  per-subordinate ready
- `i_hresp`  in  SLAVE_COUNT  per-subordinate response (1 = ERROR)
- `i_hrdata`  in  SLAVE_COUNT x DATA_WIDTH  per-subordinate read data
- `o_hsel`  out  SLAVE_COUNT  one-hot subordinate select, address phase
- `o_hready`  out  1  muxed ready to the manager bus and to every subordinate's hreadyin
- `o_hresp`  out  1  muxed response
- `o_hrdata`  out  DATA_WIDTH  muxed read data

## Operation
- Address decode is combinational. Slave index k = `i_haddr[ADDR_WIDTH-1:REGISTER_SELECT_BITS]`. `o_hsel[k]=1` iff k < SLAVE_COUNT, otherwise all zeros (unmapped). Decode is independent of `i_htrans`. `o_hsel` is forced to 0 while `i_hreset`=0.
- Data-phase state is updated only on a rising edge with `o_hready`=1. The state is:
  - `dsel_idx`: decoded index.
  - `dsel_vld`: mapped AND `i_htrans` ∈ {NONSEQ, SEQ}.
  - Default-slave FSM input.
- Response mux:
  - `dsel_vld`=1: `o_hready`=`i_hreadyout[dsel_idx]`, `o_hresp`=`i_hresp[dsel_idx]`, `o_hrdata`=`i_hrdata[dsel_idx]`.
  - FSM in ERR1/ERR2: outputs as listed below, `o_hrdata`=0.
  - Otherwise: `o_hready`=1, `o_hresp`=0, `o_hrdata`=0.
- Default-slave FSM, states DS_IDLE, DS_ERR1, DS_ERR2:
  - DS_IDLE → DS_ERR1 when `o_hready`=1 and the address phase is unmapped with `i_htrans` ∈ {NONSEQ, SEQ}.
  - DS_ERR1: `o_hready`=0, `o_hresp`=1. Goes unconditionally to DS_ERR2.
  - DS_ERR2: `o_hready`=1, `o_hresp`=1. A new address phase is sampled this cycle:
    - unmapped active → DS_ERR1;
    - mapped active → DS_IDLE with `dsel_vld`=1;
    - IDLE/BUSY → DS_IDLE.
- IDLE and BUSY transfers never raise an error and never create a data phase, regardless of address.
- Subordinate responses, including a subordinate's own two-cycle ERROR, pass through unmodified. No ERROR is generated for mapped addresses.

## Timing
- Reset values while `i_hreset`=0:
  - `o_hready`=1, `o_hresp`=0, `o_hrdata`=0, `o_hsel`=0;
  - `dsel_vld`=0, FSM=DS_IDLE.
- Reset asserted mid-transfer takes effect immediately (asynchronous). Any pending data phase or error response is abandoned.
- `o_hsel` has zero latency from `i_haddr`. The data-phase mux switches on the edge that accepts the address, so data phase = address phase + 1 cycle.
- Subordinate wait states extend the data phase one cycle per `i_hreadyout`=0. While `o_hready`=0, the registered data-phase state holds.
- Unmapped error response takes exactly 2 cycles (ERR1, ERR2).
- Back-to-back pipelining is required: a new address can be accepted on every cycle with `o_hready`=1, including DS_ERR2 and the last wait-free cycle of a subordinate data phase.

## Test plan
All scenarios use SLAVE_COUNT=3.
- **Reset:** hold `i_hreset`=0 with `i_haddr`=0x00001000 and NONSEQ.
  -> `o_hsel`=000, `o_hready`=1, `o_hresp`=0, `o_hrdata`=0. After release, `o_hsel`=010 combinationally.
- **Wait states on a read:** NONSEQ read to 0x00001004; slave1 drives `i_hreadyout`=0 for 2 cycles, then 1 with `i_hrdata[1]`=0xDEADBEEF.
  -> `o_hsel`=010 in the address cycle, `o_hready`=0 for 2 cycles, then `o_hready`=1 and `o_hrdata`=0xDEADBEEF.
- **Unmapped address:** NONSEQ to 0x00005000.
  -> `o_hsel`=000.
  -> Next cycle: `o_hready`=0, `o_hresp`=1.
  -> Following cycle: `o_hready`=1, `o_hresp`=1.
  -> Then `o_hready`=1, `o_hresp`=0 with `i_htrans`=IDLE.
- **Pipelining:** back-to-back NONSEQ to 0x00000010 (slave0 data 0x11111111), 0x00002020 (slave2 data 0x22222222), then 0x00007000 (unmapped).
  -> `o_hrdata` is 0x11111111, then 0x22222222, then the 2-cycle ERROR, with no bubble cycles.
- **IDLE and BUSY to unmapped:** `i_htrans`=IDLE, then BUSY, to 0x00009000.
  -> `o_hready`=1 and `o_hresp`=0 throughout.
- **Reset during error:** assert `i_hreset`=0 while in DS_ERR1.
  -> `o_hready`=1 and `o_hresp`=0 immediately. After release with IDLE, no ERR2 cycle appears.

Source files
------------

// File: rtl/ahb_decode_mux_if.sv
// ahb_decode_mux_if
// Bundles the manager-side address/control bus, the per-subordinate
// response bundle and the muxed response back to the manager.
//
// Handshake: a transfer is accepted in its address phase on a rising edge
// where o_hready=1; its data phase completes on the first later rising
// edge with o_hready=1. While o_hready=0 every party holds its state.
//
// Signals:
//   i_haddr, i_htrans   address phase from the manager bus
//   i_hreadyout, i_hresp, i_hrdata   per-subordinate data-phase responses
//   o_hsel              one-hot address-phase select
//   o_hready, o_hresp, o_hrdata   muxed data-phase response
//   o_dbg_state         default-subordinate FSM state (debug observation)
//
// Modports:
//   master  the environment side (drives i_*, observes o_*)
//   slave   the decode/mux block (observes i_*, drives o_*)
interface ahb_decode_mux_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int SLAVE_COUNT = 3
);
  logic [ADDR_WIDTH-1:0]                   i_haddr;
  logic [1:0]                              i_htrans;
  logic [SLAVE_COUNT-1:0]                  i_hreadyout;
  logic [SLAVE_COUNT-1:0]                  i_hresp;
  logic [SLAVE_COUNT-1:0][DATA_WIDTH-1:0]  i_hrdata;
  logic [SLAVE_COUNT-1:0]                  o_hsel;
  logic                                    o_hready;
  logic                                    o_hresp;
  logic [DATA_WIDTH-1:0]                   o_hrdata;
  logic [1:0]                              o_dbg_state;

  modport master (
    output i_haddr, i_htrans, i_hreadyout, i_hresp, i_hrdata,
    input  o_hsel, o_hready, o_hresp, o_hrdata, o_dbg_state
  );

  modport slave (
    input  i_haddr, i_htrans, i_hreadyout, i_hresp, i_hrdata,
    output o_hsel, o_hready, o_hresp, o_hrdata, o_dbg_state
  );
endinterface

// File: rtl/ahb_decode_mux.sv
// ahb_decode_mux
// Subordinate-side AHB interconnect stage. Decodes the manager address into
// a one-hot select, remembers which subordinate owns the current data phase
// and muxes that subordinate's ready/response/read data back. Unmapped
// active transfers are answered by a built-in default subordinate with a
// two-cycle ERROR (ERR1: not ready, ERR2: ready).
//
// Ports:
//   i_hclk    bus clock, rising edge
//   i_hreset  asynchronous active-low reset
//   bus       ahb_decode_mux_if.slave (address bus in, responses in,
//             select and muxed response out, FSM debug state out)
module ahb_decode_mux #(
  parameter int ADDR_WIDTH           = 32,
  parameter int DATA_WIDTH           = 32,
  parameter int SLAVE_COUNT          = 3,
  parameter int REGISTER_SELECT_BITS = 12,
  parameter int SLAVE_SELECT_BITS    = 20
) (
  input logic             i_hclk,
  input logic             i_hreset,
  ahb_decode_mux_if.slave bus
);

  localparam int IDX_W = (SLAVE_COUNT > 1) ? $clog2(SLAVE_COUNT) : 1;
  localparam logic [SLAVE_SELECT_BITS-1:0] NUM_SLAVES = SLAVE_SELECT_BITS'(SLAVE_COUNT);

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_t;

  ds_state_t                r_state;
  logic                     r_dsel_vld;
  logic [IDX_W-1:0]         r_dsel_idx;

  logic [SLAVE_SELECT_BITS-1:0] w_idx;
  logic                         w_mapped;
  logic                         w_active;
  logic                         w_hready;
  logic                         w_hresp;
  logic [DATA_WIDTH-1:0]        w_hrdata;
  logic [SLAVE_COUNT-1:0]       w_hsel;

  // Address decode: purely combinational, independent of the transfer type.
  assign w_idx    = bus.i_haddr[ADDR_WIDTH-1:REGISTER_SELECT_BITS];
  assign w_mapped = (w_idx < NUM_SLAVES);
  assign w_active = (bus.i_htrans == 2'b10) || (bus.i_htrans == 2'b11);

  always_comb begin
    w_hsel = '0;
    for (int k = 0; k < SLAVE_COUNT; k++) begin
      if (i_hreset && w_mapped && (w_idx == SLAVE_SELECT_BITS'(k))) begin
        w_hsel[k] = 1'b1;
      end
    end
  end

  // Response mux. A valid subordinate data phase and a default-slave error
  // are mutually exclusive, so the priority order here is immaterial.
  always_comb begin
    w_hready = 1'b1;
    w_hresp  = 1'b0;
    w_hrdata = '0;
    if (r_dsel_vld) begin
      for (int k = 0; k < SLAVE_COUNT; k++) begin
        if (r_dsel_idx == IDX_W'(k)) begin
          w_hready = bus.i_hreadyout[k];
          w_hresp  = bus.i_hresp[k];
          w_hrdata = bus.i_hrdata[k];
        end
      end
    end else if (r_state == DS_ERR1) begin
      w_hready = 1'b0;
      w_hresp  = 1'b1;
    end else if (r_state == DS_ERR2) begin
      w_hready = 1'b1;
      w_hresp  = 1'b1;
    end
  end

  // Data-phase state and default-slave FSM. Everything advances only on an
  // edge with hready=1, except ERR1 which always moves on to ERR2 (ERR1
  // itself holds hready low, so there is nothing else to wait for).
  always_ff @(posedge i_hclk or negedge i_hreset) begin
    if (!i_hreset) begin
      r_state    <= DS_IDLE;
      r_dsel_vld <= 1'b0;
      r_dsel_idx <= '0;
    end else begin
      case (r_state)
        DS_ERR1: begin
          r_state <= DS_ERR2;
        end
        DS_IDLE, DS_ERR2: begin
          if (w_hready) begin
            r_dsel_vld <= w_mapped && w_active;
            if (w_mapped) begin
              r_dsel_idx <= w_idx[IDX_W-1:0];
            end
            r_state <= (!w_mapped && w_active) ? DS_ERR1 : DS_IDLE;
          end
        end
        default: begin
          r_state    <= DS_IDLE;
          r_dsel_vld <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_hsel      = w_hsel;
  assign bus.o_hready    = w_hready;
  assign bus.o_hresp     = w_hresp;
  assign bus.o_hrdata    = w_hrdata;
  assign bus.o_dbg_state = r_state;

endmodule

// File: tb/tb_ahb_decode_mux.sv
// tb_ahb_decode_mux
// Directed bench for ahb_decode_mux with SLAVE_COUNT=3. A transfer-level
// model tracks what the current data phase is (nothing, subordinate k, or a
// default-slave error with cycles left) and a compare process checks every
// output on every falling edge. Directed steps add literal expectations and
// queue the read data each completed subordinate phase must return.
module tb_ahb_decode_mux;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SC = 3;

  logic clk;
  logic rst_n;

  ahb_decode_mux_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SLAVE_COUNT(SC)) bus ();

  ahb_decode_mux #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SLAVE_COUNT(SC),
    .REGISTER_SELECT_BITS(12), .SLAVE_SELECT_BITS(20)
  ) dut (
    .i_hclk   (clk),
    .i_hreset (rst_n),
    .bus      (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters / scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_kind: 0 = no data phase, 1 = subordinate m_slave, 2 = error response
  // with m_err_left cycles remaining (2 = first cycle, 1 = last cycle).
  int m_kind = 0;
  int m_slave = 0;
  int m_err_left = 0;

  function automatic logic m_ready();
    if (m_kind == 1) return bus.i_hreadyout[m_slave];
    if (m_kind == 2) return (m_err_left == 1);
    return 1'b1;
  endfunction

  function automatic logic m_resp();
    if (m_kind == 1) return bus.i_hresp[m_slave];
    if (m_kind == 2) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [DW-1:0] m_rdata();
    if (m_kind == 1) return bus.i_hrdata[m_slave];
    return '0;
  endfunction

  function automatic logic [SC-1:0] m_hsel();
    int k;
    k = int'(bus.i_haddr >> 12);
    if (!rst_n || k >= SC) return '0;
    return SC'(1 << k);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_kind = 0;
      m_err_left = 0;
    end else if (m_ready()) begin
      // Transfer completes (or none was pending): take the new address.
      if (bus.i_htrans[1]) begin
        if (int'(bus.i_haddr >> 12) < SC) begin
          m_kind = 1;
          m_slave = int'(bus.i_haddr >> 12);
        end else begin
          m_kind = 2;
          m_err_left = 2;
        end
      end else begin
        m_kind = 0;
      end
    end else if (m_kind == 2) begin
      m_err_left = m_err_left - 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic cmp_en = 1'b0;
  logic [DW-1:0] q_exp;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_hsel",   DW'(bus.o_hsel),   DW'(m_hsel()));
      chk("cyc_hready", DW'(bus.o_hready), DW'(m_ready()));
      chk("cyc_hresp",  DW'(bus.o_hresp),  DW'(m_resp()));
      chk("cyc_hrdata", bus.o_hrdata,      m_rdata());
      if (rst_n && m_kind == 1 && m_ready() && exp_q.size() > 0) begin
        q_exp = exp_q.pop_front();
        chk("sb_rdata", bus.o_hrdata, q_exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [AW-1:0] addr, input logic [1:0] trans);
    bus.i_haddr  = addr;
    bus.i_htrans = trans;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    bus.i_hreadyout = '1;
    bus.i_hresp     = '0;
    bus.i_hrdata    = '0;
    drive(32'h0000_1000, 2'b10);

    // Reset held with a mapped NONSEQ on the bus.
    step();
    cmp_en = 1'b1;
    step();
    chk("rst_hsel",   DW'(bus.o_hsel),   0);
    chk("rst_hready", DW'(bus.o_hready), 1);
    chk("rst_hresp",  DW'(bus.o_hresp),  0);
    chk("rst_hrdata", bus.o_hrdata,      0);
    rst_n = 1'b1;
    #1;
    chk("rel_hsel", DW'(bus.o_hsel), 32'b010);
    drive(32'h0000_1000, 2'b00);
    step();

    // Read to slave 1 with two wait states.
    drive(32'h0000_1004, 2'b10);
    bus.i_hreadyout[1] = 1'b0;
    exp_q.push_back(32'hDEAD_BEEF);
    #1;
    chk("ws_hsel", DW'(bus.o_hsel), 32'b010);
    step();
    drive(32'h0000_0000, 2'b00);
    chk("ws_wait1", DW'(bus.o_hready), 0);
    step();
    chk("ws_wait2", DW'(bus.o_hready), 0);
    step();
    bus.i_hreadyout[1] = 1'b1;
    bus.i_hrdata[1] = 32'hDEAD_BEEF;
    #1;
    chk("ws_done_ready", DW'(bus.o_hready), 1);
    chk("ws_done_rdata", bus.o_hrdata, 32'hDEAD_BEEF);
    step();

    // Unmapped NONSEQ.
    drive(32'h0000_5000, 2'b10);
    #1;
    chk("um_hsel", DW'(bus.o_hsel), 0);
    step();
    drive(32'h0000_5000, 2'b00);
    chk("um_err1_ready", DW'(bus.o_hready), 0);
    chk("um_err1_resp",  DW'(bus.o_hresp),  1);
    step();
    chk("um_err2_ready", DW'(bus.o_hready), 1);
    chk("um_err2_resp",  DW'(bus.o_hresp),  1);
    step();
    chk("um_post_ready", DW'(bus.o_hready), 1);
    chk("um_post_resp",  DW'(bus.o_hresp),  0);

    // Back-to-back pipeline: slave0, slave2, unmapped, then slave0 in ERR2.
    bus.i_hrdata[0] = 32'h1111_1111;
    bus.i_hrdata[2] = 32'h2222_2222;
    exp_q.push_back(32'h1111_1111);
    exp_q.push_back(32'h2222_2222);
    drive(32'h0000_0010, 2'b10);
    step();
    drive(32'h0000_2020, 2'b10);
    chk("pl_d0_ready", DW'(bus.o_hready), 1);
    chk("pl_d0_rdata", bus.o_hrdata, 32'h1111_1111);
    step();
    drive(32'h0000_7000, 2'b10);
    chk("pl_d2_ready", DW'(bus.o_hready), 1);
    chk("pl_d2_rdata", bus.o_hrdata, 32'h2222_2222);
    step();
    drive(32'h0000_7000, 2'b00);
    chk("pl_err1_ready", DW'(bus.o_hready), 0);
    chk("pl_err1_resp",  DW'(bus.o_hresp),  1);
    step();
    exp_q.push_back(32'h1111_1111);
    drive(32'h0000_0010, 2'b10);
    chk("pl_err2_ready", DW'(bus.o_hready), 1);
    chk("pl_err2_resp",  DW'(bus.o_hresp),  1);
    step();
    drive(32'h0000_0010, 2'b00);
    chk("pl_after_err_rdata", bus.o_hrdata, 32'h1111_1111);
    chk("pl_after_err_resp",  DW'(bus.o_hresp), 0);
    step();

    // IDLE then BUSY to an unmapped address.
    drive(32'h0000_9000, 2'b00);
    #1;
    chk("ib_hsel", DW'(bus.o_hsel), 0);
    step();
    drive(32'h0000_9000, 2'b01);
    chk("ib_idle_ready", DW'(bus.o_hready), 1);
    chk("ib_idle_resp",  DW'(bus.o_hresp),  0);
    step();
    drive(32'h0000_9000, 2'b00);
    chk("ib_busy_ready", DW'(bus.o_hready), 1);
    chk("ib_busy_resp",  DW'(bus.o_hresp),  0);
    step();

    // Reset asserted during ERR1.
    drive(32'h0000_5000, 2'b10);
    step();
    drive(32'h0000_5000, 2'b00);
    chk("re_err1_ready", DW'(bus.o_hready), 0);
    chk("re_err1_resp",  DW'(bus.o_hresp),  1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("re_rst_ready", DW'(bus.o_hready), 1);
    chk("re_rst_resp",  DW'(bus.o_hresp),  0);
    step();
    rst_n = 1'b1;
    #1;
    chk("re_rel_ready", DW'(bus.o_hready), 1);
    chk("re_rel_resp",  DW'(bus.o_hresp),  0);
    step();
    chk("re_noerr2_ready", DW'(bus.o_hready), 1);
    chk("re_noerr2_resp",  DW'(bus.o_hresp),  0);
    step();
    step();

    cmp_en = 1'b0;
    chk("sb_drained", DW'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
